// File: rtl/seg_digit_driver_if.sv
// Load/data handshake between the value producer and seg_digit_driver.
// Ready high means the driver can take a new byte on Load.
interface seg_digit_driver_if;
    logic       Load;
    logic [7:0] DataIn;
    logic       Ready;

    modport master (
        output Load,
        output DataIn,
        input  Ready
    );

    modport slave (
        input  Load,
        input  DataIn,
        output Ready
    );
endinterface

// File: rtl/seg_digit_driver.sv
// Two-digit seven-segment cathode driver with frame-aligned commit.
// Optional blink gating is built only when SEG_BLINK_EN is defined.
module seg_digit_driver #(
    parameter int BLANK_LEADING_ZERO = 0,
    parameter int TIMEOUT_LOG2       = 19,
    parameter int BLINK_LOG2         = 25
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Selector,
    input  logic                Blink,
    seg_digit_driver_if.slave   bus,
    output logic [6:0]          Seg,
    output logic                DP
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    localparam logic [6:0] BLANK = 7'b1111111;

    state_t                  state_q;
    logic                    ready_q;
    logic [7:0]              pend_q;
    logic [TIMEOUT_LOG2-1:0] tmo_q;
    logic                    prev_sel_q;
    logic [6:0]              pat0_q;
    logic [6:0]              pat1_q;

    logic [6:0]              pat0_d;
    logic [6:0]              pat1_d;
    logic                    boundary;
    logic                    tmo_hit;
    logic                    commit;
    logic [6:0]              seg_mux;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0:    p = 7'b1000000;
            4'h1:    p = 7'b1111001;
            4'h2:    p = 7'b0100100;
            4'h3:    p = 7'b0110000;
            4'h4:    p = 7'b0011001;
            4'h5:    p = 7'b0010010;
            4'h6:    p = 7'b0000010;
            4'h7:    p = 7'b1111000;
            4'h8:    p = 7'b0000000;
            4'h9:    p = 7'b0010000;
            4'hA:    p = 7'b0001000;
            4'hB:    p = 7'b0000011;
            4'hC:    p = 7'b1000110;
            4'hD:    p = 7'b0100001;
            4'hE:    p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    // Decode the pending byte and detect the commit conditions.
    always_comb begin
        pat0_d   = hex7(pend_q[3:0]);
        pat1_d   = hex7(pend_q[7:4]);
        if ((BLANK_LEADING_ZERO != 0) && (pend_q[7:4] == 4'h0)) begin
            pat1_d = BLANK;
        end
        boundary = prev_sel_q & ~Selector;
        tmo_hit  = &tmo_q;
        commit   = boundary | tmo_hit;
    end

    // Handshake FSM: hold one pending byte, commit it at a frame edge or timeout.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            pend_q     <= 8'h00;
            tmo_q      <= '0;
            prev_sel_q <= 1'b0;
            pat0_q     <= BLANK;
            pat1_q     <= BLANK;
        end else begin
            prev_sel_q <= Selector;
            case (state_q)
                IDLE: begin
                    if (bus.Load) begin
                        pend_q  <= bus.DataIn;
                        tmo_q   <= '0;
                        state_q <= PENDING;
                        ready_q <= 1'b0;
                    end
                end
                PENDING: begin
                    if (commit) begin
                        pat0_q  <= pat0_d;
                        pat1_q  <= pat1_d;
                        tmo_q   <= '0;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Ready = ready_q;
    assign DP        = 1'b1;

    // Pick the pattern for the digit the anode controller is driving now.
    always_comb begin
        seg_mux = Selector ? pat1_q : pat0_q;
    end

`ifdef SEG_BLINK_EN
    logic [BLINK_LOG2:0] blink_q;

    // Free-running blink phase counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + 1'b1;
        end
    end

    // Blank the cathodes during the off half of the blink period.
    always_comb begin
        Seg = (Blink && blink_q[BLINK_LOG2]) ? BLANK : seg_mux;
    end
`else
    logic [BLINK_LOG2:0] blink_unused;
    assign blink_unused = {(BLINK_LOG2 + 1){Blink}};

    // No blink hardware: the mux drives the cathodes directly.
    always_comb begin
        Seg = seg_mux;
    end
`endif

endmodule

// File: tb/tb_seg_digit_driver.sv
// Bench for seg_digit_driver: directed steps from the test plan, then
// random traffic against a timestamp-based reference model.
module tb_seg_digit_driver;

    localparam int TO = 16;

    logic       Clk;
    logic       Reset;
    logic       Selector;
    logic       Blink;
    logic [6:0] Seg0;
    logic [6:0] Seg1;
    logic       DP0;
    logic       DP1;

    seg_digit_driver_if bus0 ();
    seg_digit_driver_if bus1 ();

    seg_digit_driver #(
        .BLANK_LEADING_ZERO(0),
        .TIMEOUT_LOG2(4),
        .BLINK_LOG2(3)
    ) dut0 (
        .Clk(Clk),
        .Reset(Reset),
        .Selector(Selector),
        .Blink(Blink),
        .bus(bus0),
        .Seg(Seg0),
        .DP(DP0)
    );

    seg_digit_driver #(
        .BLANK_LEADING_ZERO(1),
        .TIMEOUT_LOG2(4),
        .BLINK_LOG2(3)
    ) dut1 (
        .Clk(Clk),
        .Reset(Reset),
        .Selector(Selector),
        .Blink(Blink),
        .bus(bus1),
        .Seg(Seg1),
        .DP(DP1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int checks = 0;
    int errors = 0;

    // reference model state
    int         cyc = 0;
    int         t_acc = 0;
    int         bcnt = 0;
    bit         m_ready = 1;
    bit         m_prev = 0;
    bit         m_vis = 0;
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_shown = 8'h00;

    function automatic logic [6:0] exp_seg(input bit sel, input bit blz, input bit blk);
        logic [6:0] p;
        if (!m_vis)
            p = 7'h7f;
        else if (sel)
            p = (blz && m_shown[7:4] == 4'h0) ? 7'h7f : tbl[m_shown[7:4]];
        else
            p = tbl[m_shown[3:0]];
`ifdef SEG_BLINK_EN
        if (blk && bcnt[3]) p = 7'h7f;
`else
        if (blk) p = p;
`endif
        return p;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input logic [7:0] d,
                        input bit sel, input bit blk);
        bit bnd;
        Reset = rst;
        bus0.Load = ld;
        bus1.Load = ld;
        bus0.DataIn = d;
        bus1.DataIn = d;
        Selector = sel;
        Blink = blk;
        @(posedge Clk);
        cyc++;
        if (rst) begin
            m_ready = 1;
            m_vis = 0;
            m_prev = 0;
            bcnt = 0;
        end else begin
            bnd = m_prev && !sel;
            if (m_ready) begin
                if (ld) begin
                    m_pend = d;
                    t_acc = cyc;
                    m_ready = 0;
                end
            end else if (bnd || (cyc - t_acc == TO)) begin
                m_shown = m_pend;
                m_vis = 1;
                m_ready = 1;
            end
            m_prev = sel;
            bcnt++;
        end
        #1;
        chk("ready0", {7'd0, bus0.Ready}, {7'd0, m_ready});
        chk("ready1", {7'd0, bus1.Ready}, {7'd0, m_ready});
        chk("seg0", {1'b0, Seg0}, {1'b0, exp_seg(sel, 0, blk)});
        chk("seg1", {1'b0, Seg1}, {1'b0, exp_seg(sel, 1, blk)});
    endtask

    task automatic idle(input int n, input bit sel);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, sel, 0);
    endtask

    initial begin
        int hold;
        bit rs;
        Reset = 1; Selector = 0; Blink = 0;
        bus0.Load = 0; bus1.Load = 0;
        bus0.DataIn = 0; bus1.DataIn = 0;

        // reset then idle
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        idle(10, 0);
        chk("rst_seg", {1'b0, Seg0}, 8'h7f);
        chk("rst_dp0", {7'd0, DP0}, 8'h01);
        chk("rst_dp1", {7'd0, DP1}, 8'h01);
        chk("rst_rdy", {7'd0, bus0.Ready}, 8'h01);

        // 3A committed at the first 1->0 Selector edge
        step(0, 1, 8'h3A, 1, 0);
        chk("3a_busy", {7'd0, bus0.Ready}, 8'h00);
        idle(7, 1);
        chk("3a_hold", {7'd0, bus0.Ready}, 8'h00);
        step(0, 0, 8'h00, 0, 0);
        chk("3a_rdy", {7'd0, bus0.Ready}, 8'h01);
        chk("3a_d0", {1'b0, Seg0}, 8'b0001000);
        step(0, 0, 8'h00, 1, 0);
        chk("3a_d1", {1'b0, Seg0}, 8'b0110000);

        // leading-zero blanking
        step(0, 1, 8'h05, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("05_d0", {1'b0, Seg1}, 8'b0010010);
        step(0, 0, 8'h00, 1, 0);
        chk("05_blz", {1'b0, Seg1}, 8'h7f);
        chk("05_noblz", {1'b0, Seg0}, 8'b1000000);

        // timeout commit with Selector held low, extra Load ignored
        step(0, 1, 8'hF8, 0, 0);
        for (int i = 1; i <= TO; i++) begin
            step(0, i == 5, 8'h77, 0, 0);
            if (i < TO) chk("to_busy", {7'd0, bus0.Ready}, 8'h00);
        end
        chk("to_rdy", {7'd0, bus0.Ready}, 8'h01);
        chk("to_seg", {1'b0, Seg0}, 8'b0000000);

        // load in the boundary cycle waits for the next boundary
        step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'h11, 0, 0);
        chk("11_busy", {7'd0, bus0.Ready}, 8'h00);
        chk("11_old", {1'b0, Seg0}, 8'b0000000);
        idle(3, 0);
        idle(3, 1);
        step(0, 0, 8'h00, 0, 0);
        chk("11_rdy", {7'd0, bus0.Ready}, 8'h01);
        chk("11_seg", {1'b0, Seg0}, 8'b1111001);

        // reset discards a pending 22
        step(0, 1, 8'h22, 0, 0);
        idle(2, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("rst_mid_rdy", {7'd0, bus0.Ready}, 8'h01);
        chk("rst_mid_seg", {1'b0, Seg0}, 8'h7f);
        idle(20, 0);
        chk("no22_d0", {1'b0, Seg0}, 8'h7f);
        step(0, 0, 8'h00, 1, 0);
        chk("no22_d1", {1'b0, Seg0}, 8'h7f);

        // randomized traffic
        hold = 0;
        rs = 1;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                rs = ~rs;
                hold = $urandom_range(1, 24);
            end
            hold--;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                 8'($urandom), rs, 1'($urandom_range(0, 1)));
        end

`ifdef SEG_BLINK_EN
        // steady blink over a few half-periods
        for (int i = 0; i < 48; i++) step(0, 0, 8'h00, 0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
